// File: rtl/fir_cfg_pkg.sv
// fir_cfg_pkg: fir slave address map, ap_ctrl bit positions and sequencer states.
package fir_cfg_pkg;
  localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
  localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h020;
  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_TAP_WR, S_TAP_RD, S_LEN_WR, S_START_WR, S_POLL_AR, S_POLL_R, S_POLL_GAP
  } state_t;
  function automatic logic [11:0] tap_addr(input logic [3:0] i);
    return ADDR_TAP_BASE + {6'd0, i, 2'd0};
  endfunction
endpackage

// File: rtl/fir_cfg_master_if.sv
// fir_cfg_master_if: AXI-lite signals without a write-response channel.
interface fir_cfg_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) ();
  logic awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [pADDR_WIDTH-1:0] awaddr, araddr;
  logic [pDATA_WIDTH-1:0] wdata, rdata;
  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_axil_port.sv
// fir_cfg_axil_port: one-shot AXI-lite write/read engine with independent AW/W tracking.
module fir_cfg_axil_port #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic req,
  input  logic rw,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] wd,
  output logic ack,
  output logic ar_hs,
  output logic [pDATA_WIDTH-1:0] rdata,
  fir_cfg_master_if.master axi
);
  logic aw_done, w_done, aw_hs, w_hs, r_hs, wr_ack;
  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs = axi.wvalid & axi.wready;
  assign ar_hs = axi.arvalid & axi.arready;
  assign r_hs = axi.rvalid & axi.rready;
  assign wr_ack = aw_done & w_done;
  assign ack = wr_ack | r_hs;
  assign rdata = axi.rdata;
  // a write is acknowledged the cycle after its later handshake; a read on the R handshake itself
  always_ff @(posedge axis_clk)
    if (!axis_rst_n) begin
      axi.awvalid <= 1'b0;
      axi.awaddr <= '0;
      axi.wvalid <= 1'b0;
      axi.wdata <= '0;
      axi.arvalid <= 1'b0;
      axi.araddr <= '0;
      axi.rready <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (aw_hs) begin
        axi.awvalid <= 1'b0;
        axi.awaddr <= '0;
      end
      if (w_hs) begin
        axi.wvalid <= 1'b0;
        axi.wdata <= '0;
      end
      if (ar_hs) begin
        axi.arvalid <= 1'b0;
        axi.araddr <= '0;
        axi.rready <= 1'b1;
      end
      if (r_hs) axi.rready <= 1'b0;
      aw_done <= (aw_done | aw_hs) & ~wr_ack;
      w_done <= (w_done | w_hs) & ~wr_ack;
      if (req & ~rw) begin
        axi.awvalid <= 1'b1;
        axi.awaddr <= addr;
        axi.wvalid <= 1'b1;
        axi.wdata <= wd;
      end
      if (req & rw) begin
        axi.arvalid <= 1'b1;
        axi.araddr <= addr;
      end
    end
endmodule

// File: rtl/fir_cfg_master.sv
// fir_cfg_master: programs fir taps and length, launches ap_start, polls ap_done.
// FIR_CFG_READBACK_EN inserts a tap readback pass that flags mismatches on err.
module fir_cfg_master
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num = 11,
  parameter int POLL_GAP = 4
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic coef_we,
  input  logic [3:0] coef_idx,
  input  logic [31:0] coef_wdata,
  input  logic [31:0] data_len,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  fir_cfg_master_if.master axi
);
  localparam logic [3:0] LAST = 4'(Tape_Num - 1);
  state_t state, next;
  logic [3:0] idx, sel;
  logic [31:0] coef [Tape_Num];
  logic [31:0] len_q;
  logic [POLL_GAP-1:0] gap;
  logic req, rw, ack, ar_hs, last, polled_done, err_q;
  logic [pADDR_WIDTH-1:0] addr;
  logic [pDATA_WIDTH-1:0] wd, rdata;
  assign last = idx == LAST;
  assign sel = last ? 4'd0 : idx + 4'd1;
  assign polled_done = rdata[AP_DONE_BIT];
  assign err = err_q;
  fir_cfg_axil_port #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_port (
    .axis_clk, .axis_rst_n, .req, .rw, .addr, .wd, .ack, .ar_hs, .rdata, .axi
  );
  // each command is issued on the cycle the FSM moves on, so valids rise with the new state
  always_comb begin
    next = state;
    req = 1'b0;
    rw = 1'b0;
    addr = '0;
    wd = '0;
    case (state)
      S_IDLE: if (start) begin
        next = S_TAP_WR;
        req = 1'b1;
        addr = pADDR_WIDTH'(tap_addr(4'd0));
        wd = pDATA_WIDTH'(coef[0]);
      end
      S_TAP_WR, S_TAP_RD: if (ack) begin
        req = 1'b1;
        if (!last) begin
          rw = state == S_TAP_RD;
          addr = pADDR_WIDTH'(tap_addr(sel));
          wd = pDATA_WIDTH'(coef[sel]);
        end
`ifdef FIR_CFG_READBACK_EN
        else if (state == S_TAP_WR) begin
          next = S_TAP_RD;
          rw = 1'b1;
          addr = pADDR_WIDTH'(tap_addr(sel));
        end
`endif
        else begin
          next = S_LEN_WR;
          addr = pADDR_WIDTH'(ADDR_DATA_LEN);
          wd = pDATA_WIDTH'(len_q);
        end
      end
      S_LEN_WR: if (ack) begin
        next = S_START_WR;
        req = 1'b1;
        addr = pADDR_WIDTH'(ADDR_AP_CTRL);
        wd = pDATA_WIDTH'(1) << AP_START_BIT;
      end
      S_START_WR: if (ack) begin
        next = S_POLL_AR;
        req = 1'b1;
        rw = 1'b1;
        addr = pADDR_WIDTH'(ADDR_AP_CTRL);
      end
      S_POLL_AR: next = ar_hs ? S_POLL_R : S_POLL_AR;
      S_POLL_R: if (ack) next = polled_done ? S_IDLE : S_POLL_GAP;
      S_POLL_GAP: if (gap == '0) begin
        next = S_POLL_AR;
        req = 1'b1;
        rw = 1'b1;
        addr = pADDR_WIDTH'(ADDR_AP_CTRL);
      end
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge axis_clk)
    if (!axis_rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      len_q <= '0;
      gap <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < Tape_Num; i++) coef[i] <= '0;
    end else begin
      state <= next;
      idx <= next != state ? 4'd0 : ack ? idx + 4'd1 : idx;
      gap <= state == S_POLL_GAP ? gap - POLL_GAP'(1) : POLL_GAP'(POLL_GAP - 1);
      if (state == S_IDLE && coef_we && coef_idx <= LAST) coef[coef_idx] <= coef_wdata;
      if (state == S_IDLE && start) begin
        busy <= 1'b1;
        done <= 1'b0;
        err_q <= 1'b0;
        len_q <= data_len;
      end
      if (state == S_POLL_R && ack && polled_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
`ifdef FIR_CFG_READBACK_EN
      if (state == S_TAP_RD && ack && rdata != pDATA_WIDTH'(coef[idx])) err_q <= 1'b1;
`endif
    end
`ifndef FIR_CFG_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif
endmodule

// File: tb/tb_fir_cfg_master.sv
// tb_fir_cfg_master: scoreboard bench with an AXI-lite fir responder model.
module tb_fir_cfg_master;
  logic clk = 1'b0, rst_n = 1'b0, coef_we = 1'b0, start = 1'b0;
  logic [3:0] coef_idx = '0;
  logic [31:0] coef_wdata = '0, data_len = '0;
  logic busy, done, err;
  fir_cfg_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axi ();
  fir_cfg_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11), .POLL_GAP(4)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .coef_we(coef_we), .coef_idx(coef_idx),
    .coef_wdata(coef_wdata), .data_len(data_len), .start(start),
    .busy(busy), .done(done), .err(err), .axi(axi)
  );
  always #5 clk = ~clk;

  typedef struct packed {logic rd; logic [11:0] a; logic [31:0] d;} txn_t;
  txn_t q[$];
  int n_cmp = 0, n_bad = 0;
  int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0, done_on = 3, poll_n = 0, gap_n = 0;
  bit corrupt = 0, rd_notdone = 0, meas_on = 0, have_a = 0, have_d = 0, aw_st = 0, w_st = 0;
  logic [31:0] mem [16];
  logic [31:0] rd_next = '0, pd = '0, st_d = '0;
  logic [11:0] pa = '0, st_a = '0;
  logic [3:0] t;
  int coefs [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void sb_check(input txn_t act);
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_txn: got %0h expected none", act);
    end else check("txn", 64'(act), 64'(q.pop_front()));
  endfunction

  task automatic push(input bit rd, input logic [11:0] a, input logic [31:0] d);
    q.push_back('{rd, a, d});
  endtask

  task automatic push_seq(input logic [31:0] len, input int polls, input bit zero_taps);
    for (int i = 0; i < 11; i++) push(1'b0, 12'h020 + 12'(4 * i), zero_taps ? 32'd0 : 32'(coefs[i]));
`ifdef FIR_CFG_READBACK_EN
    for (int i = 0; i < 11; i++) push(1'b1, 12'h020 + 12'(4 * i), 32'd0);
`endif
    push(1'b0, 12'h010, len);
    push(1'b0, 12'h000, 32'h1);
    for (int i = 0; i < polls; i++) push(1'b1, 12'h000, 32'd0);
  endtask

  assign axi.awready = axi.awvalid && aw_cnt >= aw_dly;
  assign axi.wready = axi.wvalid && w_cnt >= w_dly;
  assign axi.arready = axi.arvalid;

  always @(posedge clk)
    if (!rst_n) begin
      aw_cnt <= 0;
      w_cnt <= 0;
      axi.rvalid <= 1'b0;
      axi.rdata <= '0;
    end else begin
      aw_cnt <= axi.awready ? 0 : axi.awvalid ? aw_cnt + 1 : aw_cnt;
      w_cnt <= axi.wready ? 0 : axi.wvalid ? w_cnt + 1 : w_cnt;
      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
        axi.rdata <= '0;
      end
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rdata <= rd_next;
      end
    end

  // monitor: pairs AW/W into one write, checks payload stability and the poll spacing
  always @(negedge clk)
    if (!rst_n) begin
      have_a = 0;
      have_d = 0;
      meas_on = 0;
      aw_st = 0;
      w_st = 0;
    end else begin
      if (aw_st) check("aw_stable", 64'({axi.awvalid, axi.awaddr}), 64'({1'b1, st_a}));
      if (w_st) check("w_stable", 64'({axi.wvalid, axi.wdata}), 64'({1'b1, st_d}));
      aw_st = axi.awvalid && !axi.awready;
      st_a = axi.awaddr;
      w_st = axi.wvalid && !axi.wready;
      st_d = axi.wdata;
      if (axi.awvalid && axi.awready) begin
        if (have_a) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dup_aw: got %0h expected no second address", axi.awaddr);
        end
        pa = axi.awaddr;
        have_a = 1;
      end
      if (axi.wvalid && axi.wready) begin
        if (have_d) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dup_w: got %0h expected no second data", axi.wdata);
        end
        pd = axi.wdata;
        have_d = 1;
      end
      if (have_a && have_d) begin
        sb_check('{1'b0, pa, pd});
        if (pa >= 12'h020) mem[4'((pa - 12'h020) >> 2)] = pd;
        have_a = 0;
        have_d = 0;
      end
      if (axi.arvalid && axi.arready) begin
        sb_check('{1'b1, axi.araddr, 32'd0});
        if (axi.araddr == 12'h000) begin
          poll_n++;
          rd_notdone = poll_n != done_on;
          rd_next = rd_notdone ? 32'h0 : 32'h2;
        end else begin
          t = 4'((axi.araddr - 12'h020) >> 2);
          rd_notdone = 0;
          rd_next = (corrupt && t == 4'd5) ? 32'd62 : mem[t];
        end
      end
      if (meas_on) begin
        if (axi.arvalid) begin
          check("poll_gap", 64'(gap_n), 64'(4));
          meas_on = 0;
        end else gap_n++;
      end
      if (axi.rvalid && axi.rready && rd_notdone) begin
        meas_on = 1;
        gap_n = 0;
      end
    end

  task automatic wr_coef(input int i, input logic [31:0] v);
    coef_we = 1'b1;
    coef_idx = 4'(i);
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] len);
    start = 1'b1;
    data_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(n < 3000), 64'(1));
  endtask

  task automatic finish_checks(input string name, input bit exp_err);
    check({name, "_done"}, 64'(done), 64'(1));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_drain"}, 64'(q.size()), 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", 64'({busy, done, err}), 64'(0));
    check("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}), 64'(0));
    check("rst_payload", 64'({axi.awaddr, axi.wdata, axi.araddr}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) wr_coef(i, 32'(coefs[i]));
    wr_coef(11, 32'd123);

    done_on = 3;
    poll_n = 0;
    push_seq(32'd600, 3, 1'b0);
    pulse_start(32'd600);
    repeat (5) @(negedge clk);
    check("t1_busy", 64'(busy), 64'(1));
    start = 1'b1;
    data_len = 32'd7;
    coef_we = 1'b1;
    coef_idx = 4'd0;
    coef_wdata = 32'd999;
    @(negedge clk);
    start = 1'b0;
    coef_we = 1'b0;
    wait_idle("t1");
    finish_checks("t1", 1'b0);

    aw_dly = 3;
    done_on = 1;
    poll_n = 0;
    push_seq(32'd600, 1, 1'b0);
    pulse_start(32'd600);
    check("t2_done_clr", 64'(done), 64'(0));
    wait_idle("t2");
    finish_checks("t2", 1'b0);

    aw_dly = 0;
    w_dly = 3;
    poll_n = 0;
    push_seq(32'd5, 1, 1'b0);
    pulse_start(32'd5);
    wait_idle("t3");
    finish_checks("t3", 1'b0);

    w_dly = 0;
    corrupt = 1;
    done_on = 2;
    poll_n = 0;
    push_seq(32'd40, 2, 1'b0);
    pulse_start(32'd40);
    wait_idle("t4");
`ifdef FIR_CFG_READBACK_EN
    finish_checks("t4", 1'b1);
`else
    finish_checks("t4", 1'b0);
`endif
    corrupt = 0;

    aw_dly = 50;
    done_on = 1;
    poll_n = 0;
    push_seq(32'd600, 1, 1'b0);
    pulse_start(32'd600);
    n = 0;
    while (!(axi.awvalid && axi.awaddr == 12'h010) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_len", 64'(n < 2000), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}), 64'(0));
    check("t5_flags", 64'({busy, done, err}), 64'(0));
    check("t5_payload", 64'({axi.awaddr, axi.wdata}), 64'(0));
    q.delete();
    rst_n = 1'b1;
    aw_dly = 0;
    poll_n = 0;
    @(negedge clk);
    push_seq(32'd600, 1, 1'b1);
    pulse_start(32'd600);
    wait_idle("t5");
    finish_checks("t5", 1'b0);

    done_on = 0;
    poll_n = 0;
    push_seq(32'd9, 4, 1'b1);
    pulse_start(32'd9);
    n = 0;
    while (poll_n < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_polls", 64'(poll_n >= 4), 64'(1));
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'(1));
    check("t6_drain", 64'(q.size()), 64'(0));
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", 64'(busy), 64'(0));
    q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
